// File: rtl/data_pair_id_alloc_pkg.sv
// data_pair_id_alloc_pkg
// Shared types for the key-to-ID allocator: the allocator FSM state.
package data_pair_id_alloc_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RESP = 2'd1,
    ST_DEL  = 2'd2
  } alloc_state_t;

endpackage

// File: rtl/data_pair_id_alloc_if.sv
// data_pair_id_alloc_if
// Bundles every handshake of the allocator.
//   req  : key request in        (req_valid/req_ready/req_data)
//   rsp  : ID response out       (rsp_valid/rsp_ready/rsp_data/rsp_hit/rsp_err)
//   pair : new {key,id} binding  (pair_valid/pair_ready/pair_data)
//   rel  : ID release in         (rel_valid/rel_ready/rel_data, rel_err pulse)
//   del  : delete toward the map (del_valid/del_ready/del_data)
//   used : bound slot count
// slave = allocator side, master = client/map side.
interface data_pair_id_alloc_if #(
  parameter int unsigned ISIZE = 8,
  parameter int unsigned OSIZE = 3,
  parameter int unsigned NUM   = 8
);
  import data_pair_id_alloc_pkg::*;

  logic                      req_valid;
  logic                      req_ready;
  logic [ISIZE-1:0]          req_data;
  logic                      rsp_valid;
  logic                      rsp_ready;
  logic [OSIZE-1:0]          rsp_data;
  logic                      rsp_hit;
  logic                      rsp_err;
  logic                      pair_valid;
  logic                      pair_ready;
  logic [ISIZE+OSIZE-1:0]    pair_data;
  logic                      rel_valid;
  logic                      rel_ready;
  logic [OSIZE-1:0]          rel_data;
  logic                      del_valid;
  logic                      del_ready;
  logic [OSIZE-1:0]          del_data;
  logic                      rel_err;
  logic [$clog2(NUM+1)-1:0]  used;

  modport slave (
    input  req_valid, req_data, rsp_ready, pair_ready, rel_valid, rel_data, del_ready,
    output req_ready, rsp_valid, rsp_data, rsp_hit, rsp_err, pair_valid, pair_data,
           rel_ready, del_valid, del_data, rel_err, used
  );

  modport master (
    output req_valid, req_data, rsp_ready, pair_ready, rel_valid, rel_data, del_ready,
    input  req_ready, rsp_valid, rsp_data, rsp_hit, rsp_err, pair_valid, pair_data,
           rel_ready, del_valid, del_data, rel_err, used
  );

endinterface

// File: rtl/data_pair_id_alloc_first_free.sv
// data_pair_first_free
// Combinational lowest-zero finder over the slot valid vector.
//   vld      : slot occupied flags
//   idx      : index of the lowest free slot (0 when none)
//   any_free : at least one slot is free
module data_pair_first_free #(
  parameter int unsigned NUM = 8,
  parameter int unsigned IW  = $clog2(NUM)
) (
  input  logic [NUM-1:0] vld,
  output logic [IW-1:0]  idx,
  output logic           any_free
);

  always_comb begin
    idx      = '0;
    any_free = 1'b0;
    for (int unsigned i = 0; i < NUM; i++) begin
      if (!vld[i] && !any_free) begin
        idx      = IW'(i);
        any_free = 1'b1;
      end
    end
  end

endmodule

// File: rtl/data_pair_id_alloc.sv
// data_pair_id_alloc
// Key-to-ID allocator feeding a downstream pair map. A request returns the
// existing ID on a hit, else binds the lowest free slot and emits {key,id}
// on the pair channel. Releases free a slot and emit a delete.
//   clk  : rising-edge clock
//   rst  : asynchronous active-high reset
//   bus  : all handshakes (see data_pair_id_alloc_if)
module data_pair_id_alloc
  import data_pair_id_alloc_pkg::*;
#(
  parameter int unsigned ISIZE = 8,
  parameter int unsigned OSIZE = 3,
  parameter int unsigned NUM   = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  data_pair_id_alloc_if.slave   bus
);

  localparam int unsigned UW = $clog2(NUM+1);

  alloc_state_t       state;
  logic [ISIZE-1:0]   key [NUM];
  logic [NUM-1:0]     vld;
  logic [UW-1:0]      used_q;

  logic               hit;
  logic [OSIZE-1:0]   hit_idx;
  logic [OSIZE-1:0]   free_idx;
  logic               any_free;
  logic               rel_ok;
  logic               rsp_done;
  logic               pair_done;

  data_pair_first_free #(.NUM(NUM), .IW(OSIZE)) u_first_free (
    .vld      (vld),
    .idx      (free_idx),
    .any_free (any_free)
  );

  // Only occupied slots take part in the lookup.
  always_comb begin
    hit     = 1'b0;
    hit_idx = '0;
    for (int unsigned i = 0; i < NUM; i++) begin
      if (vld[i] && key[i] == bus.req_data && !hit) begin
        hit     = 1'b1;
        hit_idx = OSIZE'(i);
      end
    end
  end

  always_comb begin
    rel_ok    = (32'(bus.rel_data) < NUM) && vld[bus.rel_data];
    // A channel counts as done if already idle or handshaking this cycle.
    rsp_done  = !bus.rsp_valid  || bus.rsp_ready;
    pair_done = !bus.pair_valid || bus.pair_ready;
  end

  assign bus.req_ready = (state == ST_IDLE);
  assign bus.rel_ready = (state == ST_IDLE) && !bus.req_valid;
  assign bus.used      = used_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= ST_IDLE;
      vld            <= '0;
      for (int unsigned i = 0; i < NUM; i++) key[i] <= '0;
      used_q         <= '0;
      bus.rsp_valid  <= 1'b0;
      bus.rsp_data   <= '0;
      bus.rsp_hit    <= 1'b0;
      bus.rsp_err    <= 1'b0;
      bus.pair_valid <= 1'b0;
      bus.pair_data  <= '0;
      bus.del_valid  <= 1'b0;
      bus.del_data   <= '0;
      bus.rel_err    <= 1'b0;
    end else begin
      bus.rel_err <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (bus.req_valid) begin
            bus.rsp_valid <= 1'b1;
            state         <= ST_RESP;
            if (hit) begin
              bus.rsp_data <= hit_idx;
              bus.rsp_hit  <= 1'b1;
              bus.rsp_err  <= 1'b0;
            end else if (any_free) begin
              key[free_idx]  <= bus.req_data;
              vld[free_idx]  <= 1'b1;
              used_q         <= used_q + UW'(1);
              bus.rsp_data   <= free_idx;
              bus.rsp_hit    <= 1'b0;
              bus.rsp_err    <= 1'b0;
              bus.pair_valid <= 1'b1;
              bus.pair_data  <= {bus.req_data, free_idx};
            end else begin
              bus.rsp_data <= '0;
              bus.rsp_hit  <= 1'b0;
              bus.rsp_err  <= 1'b1;
            end
          end else if (bus.rel_valid) begin
            if (rel_ok) begin
              vld[bus.rel_data] <= 1'b0;
              used_q            <= used_q - UW'(1);
              bus.del_valid     <= 1'b1;
              bus.del_data      <= bus.rel_data;
              state             <= ST_DEL;
            end else begin
              bus.rel_err <= 1'b1;
            end
          end
        end
        ST_RESP: begin
          if (bus.rsp_valid && bus.rsp_ready)   bus.rsp_valid  <= 1'b0;
          if (bus.pair_valid && bus.pair_ready) bus.pair_valid <= 1'b0;
          if (rsp_done && pair_done)            state          <= ST_IDLE;
        end
        ST_DEL: begin
          if (bus.del_ready) begin
            bus.del_valid <= 1'b0;
            state         <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_data_pair_id_alloc.sv
// tb_data_pair_id_alloc
// Self-checking bench: directed scenarios plus randomized request/release
// traffic, compared against a key->id map model.
module tb_data_pair_id_alloc;

  localparam int unsigned ISIZE = 8;
  localparam int unsigned OSIZE = 3;
  localparam int unsigned NUM   = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  data_pair_id_alloc_if #(.ISIZE(ISIZE), .OSIZE(OSIZE), .NUM(NUM)) bus ();

  data_pair_id_alloc #(.ISIZE(ISIZE), .OSIZE(OSIZE), .NUM(NUM)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: key -> id map plus slot ownership.
  int id_of [int];
  int key_of [NUM];
  bit busy [NUM];
  int mused;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    else n_pass++;
  endtask

  function automatic int lowest_free();
    for (int i = 0; i < int'(NUM); i++) if (!busy[i]) return i;
    return -1;
  endfunction

  task automatic model_clear();
    id_of.delete();
    for (int i = 0; i < int'(NUM); i++) begin busy[i] = 1'b0; key_of[i] = 0; end
    mused = 0;
  endtask

  // Called at a negedge with the DUT idle.
  task automatic do_req(input logic [7:0] k, input int stall_rsp, input int stall_pair);
    int  e_id;
    bit  e_hit, e_err, e_pair;
    int  f, c;
    logic [10:0] e_pd;
    e_id = 0; e_hit = 0; e_err = 0; e_pair = 0;
    if (id_of.exists(int'(k))) begin
      e_id = id_of[int'(k)]; e_hit = 1;
    end else begin
      f = lowest_free();
      if (f < 0) e_err = 1;
      else begin
        e_id = f; e_pair = 1; busy[f] = 1; key_of[f] = int'(k);
        id_of[int'(k)] = f; mused++;
      end
    end
    e_pd = {k, 3'(e_id)};
    check("req_ready_idle", 32'(bus.req_ready), 32'd1);
    bus.req_valid = 1'b1;
    bus.req_data  = k;
    #1 check("rel_ready_prio", 32'(bus.rel_ready), 32'd0);
    @(posedge clk); @(negedge clk);
    bus.req_valid = 1'b0;
    check("rsp_valid", 32'(bus.rsp_valid), 32'd1);
    check("rsp_data", 32'(bus.rsp_data), 32'(e_id));
    check("rsp_hit", 32'(bus.rsp_hit), 32'(e_hit));
    check("rsp_err", 32'(bus.rsp_err), 32'(e_err));
    check("pair_valid", 32'(bus.pair_valid), 32'(e_pair));
    if (e_pair) check("pair_data", 32'(bus.pair_data), 32'(e_pd));
    check("used", 32'(bus.used), 32'(mused));
    c = 0;
    while ((bus.rsp_valid || bus.pair_valid) && c < 20) begin
      bus.rsp_ready  = (c >= stall_rsp);
      bus.pair_ready = (c >= stall_pair);
      check("req_ready_busy", 32'(bus.req_ready), 32'd0);
      check("rel_ready_busy", 32'(bus.rel_ready), 32'd0);
      if (bus.rsp_valid)  check("rsp_data_stable", 32'(bus.rsp_data), 32'(e_id));
      if (bus.pair_valid) check("pair_data_stable", 32'(bus.pair_data), 32'(e_pd));
      @(posedge clk); @(negedge clk);
      c++;
    end
    if (c >= 20) check("resp_timeout", 32'd1, 32'd0);
    check("idle_after_resp", 32'(bus.req_ready), 32'd1);
    bus.rsp_ready  = 1'b1;
    bus.pair_ready = 1'b1;
  endtask

  task automatic do_rel(input int id);
    bus.rel_valid = 1'b1;
    bus.rel_data  = 3'(id);
    #1 check("rel_ready", 32'(bus.rel_ready), 32'd1);
    @(posedge clk); @(negedge clk);
    bus.rel_valid = 1'b0;
    if (busy[id]) begin
      busy[id] = 1'b0;
      id_of.delete(key_of[id]);
      mused--;
      check("del_valid", 32'(bus.del_valid), 32'd1);
      check("del_data", 32'(bus.del_data), 32'(id));
      check("rel_err_ok", 32'(bus.rel_err), 32'd0);
      check("used_rel", 32'(bus.used), 32'(mused));
      @(posedge clk); @(negedge clk);
      check("del_done", 32'(bus.del_valid), 32'd0);
      check("idle_after_del", 32'(bus.req_ready), 32'd1);
    end else begin
      check("rel_err_pulse", 32'(bus.rel_err), 32'd1);
      check("no_del", 32'(bus.del_valid), 32'd0);
      check("used_unchanged", 32'(bus.used), 32'(mused));
      @(posedge clk); @(negedge clk);
      check("rel_err_end", 32'(bus.rel_err), 32'd0);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_rsp_valid"},  32'(bus.rsp_valid),  32'd0);
    check({tag, "_pair_valid"}, 32'(bus.pair_valid), 32'd0);
    check({tag, "_del_valid"},  32'(bus.del_valid),  32'd0);
    check({tag, "_rsp_hit"},    32'(bus.rsp_hit),    32'd0);
    check({tag, "_rsp_err"},    32'(bus.rsp_err),    32'd0);
    check({tag, "_rel_err"},    32'(bus.rel_err),    32'd0);
    check({tag, "_rsp_data"},   32'(bus.rsp_data),   32'd0);
    check({tag, "_pair_data"},  32'(bus.pair_data),  32'd0);
    check({tag, "_del_data"},   32'(bus.del_data),   32'd0);
    check({tag, "_used"},       32'(bus.used),       32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1;
    bus.req_valid = 1'b0; bus.req_data = '0;
    bus.rsp_ready = 1'b1; bus.pair_ready = 1'b1;
    bus.rel_valid = 1'b0; bus.rel_data = '0;
    bus.del_ready = 1'b1;
    model_clear();
    repeat (2) @(negedge clk);
    check_all_zero("reset");
    check("reset_req_ready", 32'(bus.req_ready), 32'd1);
    rst = 1'b0;
    @(negedge clk);

    // Basic allocation, then a hit.
    do_req(8'h11, 0, 0);
    do_req(8'h22, 0, 0);
    do_req(8'h33, 0, 0);
    check("used_3", 32'(bus.used), 32'd3);
    do_req(8'h22, 0, 0);

    // Fill the table, miss when full, free slot 5 and reuse it.
    for (int i = 4; i <= 8; i++) do_req(8'(i * 8'h11), 0, 0);
    check("used_full", 32'(bus.used), 32'd8);
    do_req(8'h99, 0, 0);
    do_rel(5);
    do_req(8'h99, 0, 0);

    // Pair channel stalled while the response completes.
    do_rel(2);
    do_req(8'hA5, 0, 4);

    // Request and release presented together: request wins.
    bus.rel_valid = 1'b1;
    bus.rel_data  = 3'd3;
    do_req(8'h11, 0, 0);
    do_rel(3);

    // Release of an unbound ID.
    do_rel(6);
    do_rel(6);

    // Randomized traffic.
    for (int n = 0; n < 200; n++) begin
      if ($urandom_range(0, 99) < 60)
        do_req(8'(8'h40 + $urandom_range(0, 11)), int'($urandom_range(0, 3)),
               int'($urandom_range(0, 3)));
      else
        do_rel(int'($urandom_range(0, NUM - 1)));
    end

    // Reset while a pair is pending.
    do_rel(0);
    bus.rsp_ready  = 1'b0;
    bus.pair_ready = 1'b0;
    bus.req_valid  = 1'b1;
    bus.req_data   = 8'hC3;
    @(posedge clk); @(negedge clk);
    bus.req_valid = 1'b0;
    check("pre_reset_pair_valid", 32'(bus.pair_valid), 32'd1);
    rst = 1'b1;
    #1 check_all_zero("midrst");
    model_clear();
    @(negedge clk);
    rst = 1'b0;
    bus.rsp_ready  = 1'b1;
    bus.pair_ready = 1'b1;
    @(negedge clk);
    do_req(8'h11, 0, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
